video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Generates raster timing for the HDMI output path: horizontal/vertical counters, sync pulses, data-enable and pixel coordinates. Sits directly upstream of the three TMDS encoders. `o_de` drives their data-enable, `{o_vsync, o_hsync}` drives the blue-channel control input, and `o_x`/`o_y` address the pixel source. Default parameters give CEA 1280x720p60 on a 74.25 MHz pixel clock.

## Interface
- `H_ACTIVE`, default 1280: active pixels per line
- `H_FP`, default 110: horizontal front porch, in pixels
- `H_SYNC`, default 40: hsync width, in pixels
- `H_BP`, default 220: horizontal back porch, in pixels
- `V_ACTIVE`, default 720: active lines per frame
- `V_FP`, default 5: vertical front porch, in lines
- `V_SYNC`, default 5: vsync width, in lines
- `V_BP`, default 20: vertical back porch, in lines
- `H_POL`, default 1: hsync active level (1 = active-high)
- `V_POL`, default 1: vsync active level
- `i_clk`, input, 1: pixel clock
- `i_rst_n`, input, 1: asynchronous active-low reset
- `i_en`, input, 1: run enable; low holds the generator at the frame origin
- `o_hsync`, output, 1: horizontal sync at polarity `H_POL`
- `o_vsync`, output, 1: vertical sync at polarity `V_POL`
- `o_de`, output, 1: active-video data enable
- `o_x`, output, 12: horizontal pixel coordinate, meaningful while `o_de` is high
- `o_y`, output, 12: vertical line coordinate, meaningful while `o_de` is high
- `o_line_start`, output, 1: one-cycle strobe on the first active pixel of each active line
- `o_frame_start`, output, 1: one-cycle strobe on pixel (0,0) of each frame

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` and `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP`. Both must be ≤ 4096; a larger value is an elaboration error.
- Counters:
  - `h_cnt` counts 0 to `H_TOTAL-1`, incrementing every enabled cycle and wrapping to 0.
  - `v_cnt` increments only on an `h_cnt` wrap; it wraps to 0 when it is at `V_TOTAL-1` and `h_cnt` wraps.
- Per-line regions in `h_cnt` order: active `[0, H_ACTIVE)`, front porch, sync `[H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)`, back porch. Vertical regions follow the same order on `v_cnt`.
- Output decode:
  - `o_de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`
  - `o_hsync` is active in the h sync region on every line, including vertical blanking.
  - `o_vsync` is active for every cycle of lines in the v sync region, so it changes only at `h_cnt == 0`.
- Coordinates: `o_x = h_cnt` and `o_y = v_cnt`, zero-extended to 12 bits. Their values outside `o_de` are don't-care for consumers, but the bench checks them equal to the counters.
- Strobes:
  - `o_line_start = o_de && h_cnt == 0`
  - `o_frame_start = h_cnt == 0 && v_cnt == 0`
- `i_en` low:
  - Counters are synchronously cleared to 0.
  - All outputs take their reset values.
  - On the rising edge of `i_en`, generation restarts from (0,0).
- Reset mid-frame: counters and outputs go immediately (asynchronously) to reset values. There is no partial-frame recovery; the next frame starts cleanly.

## Timing
- All outputs are registered, decoded from counter state one cycle ahead, so every output is mutually phase-aligned. There is no combinational path from `i_en` to the outputs.
- Reset values: `o_de = 0`, `o_hsync = ~H_POL`, `o_vsync = ~V_POL`, `o_x = 0`, `o_y = 0`, `o_line_start = 0`, `o_frame_start = 0`.
- Start-up: if `i_en` is high at reset release, the first edge loads the pixel (0,0) outputs (`o_de`, `o_frame_start` and `o_line_start` all high). Each later edge advances one pixel.
- Steady state:
  - Line period is exactly `H_TOTAL` cycles; frame period is exactly `H_TOTAL*V_TOTAL` cycles.
  - `o_frame_start` recurs every `H_TOTAL*V_TOTAL` cycles.
- Downstream obligation: the TMDS encoders add 2 cycles of latency to de, ctrl and pixel alike. The pixel source must therefore present data for (`o_x`, `o_y`) in the same cycle as `o_de`, i.e. it needs a zero-latency or pre-fetched lookup.

## Structure
- Package `video_timing_pkg` holds:
  - named mode constants for 720p60 and 640x480p60 (active, porch, sync, polarity);
  - the `COORD_W = 12` constant.
- Sub-module `timing_axis_counter`:
  - parameters: active, front porch, sync and back-porch lengths;
  - ports: `i_clk`, `i_rst_n`, `i_clr`, `i_step`, `o_cnt`, `o_wrap`, `o_active`, `o_sync_next`.
  - Instantiated twice. The horizontal instance has `i_step = 1`. The vertical instance has `i_step` = the horizontal `o_wrap`.
- The top level performs output registration, polarity application and strobe generation.

## Test plan
All scenarios except the last use small parameters: H = 8/2/2/2 (total 14), V = 4/1/1/1 (total 7), `H_POL = 1`, `V_POL = 0`.

- **Reset then enable:** hold `i_rst_n` low, release with `i_en = 1` → first edge gives `o_de = 1`, `o_x = 0`, `o_y = 0`, `o_frame_start = 1`; `o_hsync = 0` and `o_vsync = 1` while in reset.
- **Line timing:** run one line →
  - `o_de` high for 8 cycles (`o_x` 0..7);
  - `o_hsync` high on cycles 10–11;
  - next `o_line_start` 14 cycles after the first.
- **Frame timing:** run 3 frames →
  - `o_frame_start` spacing exactly 98 cycles;
  - `o_vsync` low for exactly 14 cycles per frame, covering line 5;
  - 32 `o_de` cycles per frame.
- **Enable drop mid-frame:** drop `i_en` at pixel (5,2) for 3 cycles, then raise it → outputs at reset values during the gap; the first edge after the rise gives (0,0) with `o_frame_start = 1`.
- **Async reset mid-line:** assert `i_rst_n` low at `h_cnt = 11` → `o_hsync` drops to 0 without waiting for a clock edge; restart matches the reset-then-enable scenario.
- **Default 720p:** run 1 frame → 1650 cycles per line, 750 lines, 921600 `o_de` cycles, hsync width 40.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: coordinate width and named video modes.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package video_timing_pkg;

   // Coordinate / counter width; every axis total must fit in this many bits.
   localparam int COORD_W         = 12;
   localparam int COORD_MAX_TOTAL = 1 << COORD_W;

   // CEA 1280x720p60 @ 74.25 MHz, positive syncs.
   localparam int VT_720P_H_ACTIVE = 1280;
   localparam int VT_720P_H_FP     = 110;
   localparam int VT_720P_H_SYNC   = 40;
   localparam int VT_720P_H_BP     = 220;
   localparam int VT_720P_V_ACTIVE = 720;
   localparam int VT_720P_V_FP     = 5;
   localparam int VT_720P_V_SYNC   = 5;
   localparam int VT_720P_V_BP     = 20;
   localparam bit VT_720P_H_POL    = 1'b1;
   localparam bit VT_720P_V_POL    = 1'b1;

   // VGA 640x480p60 @ 25.175 MHz, negative syncs.
   localparam int VT_480P_H_ACTIVE = 640;
   localparam int VT_480P_H_FP     = 16;
   localparam int VT_480P_H_SYNC   = 96;
   localparam int VT_480P_H_BP     = 48;
   localparam int VT_480P_V_ACTIVE = 480;
   localparam int VT_480P_V_FP     = 10;
   localparam int VT_480P_V_SYNC   = 2;
   localparam int VT_480P_V_BP     = 33;
   localparam bit VT_480P_H_POL    = 1'b0;
   localparam bit VT_480P_V_POL    = 1'b0;

   // Length of one axis (line in pixels, or frame in lines).
   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter with active / sync region decode.
// Latency: count advances on the edge after i_step; decodes are combinational from the count.
// Backpressure: none; i_clr has priority over i_step.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_clr             synchronous clear to 0
//   i_step            advance by one position this cycle
//   o_cnt             current position
//   o_wrap            stepping out of the last position this cycle (feeds the next axis)
//   o_active          position is inside the active region
//   o_sync_next       position is inside the sync region (registered by the caller)
module timing_axis_counter
   import video_timing_pkg::*;
#(
   parameter int ACTIVE = VT_720P_H_ACTIVE,
   parameter int FP     = VT_720P_H_FP,
   parameter int SYNC   = VT_720P_H_SYNC,
   parameter int BP     = VT_720P_H_BP
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clr,
   input  logic               i_step,
   output logic [COORD_W-1:0] o_cnt,
   output logic               o_wrap,
   output logic               o_active,
   output logic               o_sync_next
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   if (TOTAL > COORD_MAX_TOTAL) begin : g_total_too_large
      $error("timing_axis_counter: total %0d exceeds %0d", TOTAL, COORD_MAX_TOTAL);
   end

   // Region bounds are one bit wider than the counter so an edge at exactly
   // 2**COORD_W (zero back porch on a maximal axis) is still representable.
   localparam logic [COORD_W:0]   ACT_END  = (COORD_W+1)'(ACTIVE);
   localparam logic [COORD_W:0]   SYNC_BEG = (COORD_W+1)'(ACTIVE + FP);
   localparam logic [COORD_W:0]   SYNC_END = (COORD_W+1)'(ACTIVE + FP + SYNC);
   localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

   logic [COORD_W-1:0] cnt_q, cnt_d;
   logic [COORD_W:0]   cnt_ext;
   logic               at_last;

   always_comb begin
      cnt_ext     = {1'b0, cnt_q};
      at_last     = (cnt_q == LAST);
      o_wrap      = i_step & at_last & ~i_clr;
      o_active    = (cnt_ext < ACT_END);
      o_sync_next = (cnt_ext >= SYNC_BEG) && (cnt_ext < SYNC_END);

      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_step) begin
         cnt_d = at_last ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, polarity-adjusted syncs, data enable, coordinates, strobes.
// Latency: all outputs registered; each edge presents the decode of the counter state it leaves.
// Backpressure: none; i_en low clears the counters and forces outputs to reset values.
//
// Ports:
//   i_clk, i_rst_n            pixel clock, asynchronous active-low reset
//   i_en                      run enable; low parks the raster at (0,0)
//   o_hsync, o_vsync          syncs at H_POL / V_POL active level
//   o_de                      active-video data enable
//   o_x, o_y                  pixel coordinates (equal to the counters at all times)
//   o_line_start              first active pixel of each active line
//   o_frame_start             pixel (0,0) of each frame
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = VT_720P_H_ACTIVE,
   parameter int H_FP     = VT_720P_H_FP,
   parameter int H_SYNC   = VT_720P_H_SYNC,
   parameter int H_BP     = VT_720P_H_BP,
   parameter int V_ACTIVE = VT_720P_V_ACTIVE,
   parameter int V_FP     = VT_720P_V_FP,
   parameter int V_SYNC   = VT_720P_V_SYNC,
   parameter int V_BP     = VT_720P_V_BP,
   parameter bit H_POL    = VT_720P_H_POL,
   parameter bit V_POL    = VT_720P_V_POL
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_de,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic               o_line_start,
   output logic               o_frame_start
);

   logic [COORD_W-1:0] h_cnt, v_cnt;
   logic               h_wrap, h_active, h_sync;
   logic               v_wrap_unused, v_active, v_sync;
   logic               cnt_clr;

   assign cnt_clr = ~i_en;

   timing_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (cnt_clr),
      .i_step      (1'b1),
      .o_cnt       (h_cnt),
      .o_wrap      (h_wrap),
      .o_active    (h_active),
      .o_sync_next (h_sync)
   );

   // Vertical axis advances once per line, on the horizontal wrap.
   timing_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (cnt_clr),
      .i_step      (h_wrap),
      .o_cnt       (v_cnt),
      .o_wrap      (v_wrap_unused),
      .o_active    (v_active),
      .o_sync_next (v_sync)
   );

   logic               de_q, de_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic               h_origin, v_origin;

   always_comb begin
      h_origin = (h_cnt == '0);
      v_origin = (v_cnt == '0);

      de_d          = 1'b0;
      hsync_d       = ~H_POL;
      vsync_d       = ~V_POL;
      x_d           = '0;
      y_d           = '0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      // i_en only gates the registered values, so it never reaches the pins combinationally.
      if (i_en) begin
         de_d          = h_active & v_active;
         hsync_d       = h_sync ? H_POL : ~H_POL;
         vsync_d       = v_sync ? V_POL : ~V_POL;
         x_d           = h_cnt;
         y_d           = v_cnt;
         line_start_d  = h_active & v_active & h_origin;
         frame_start_d = h_origin & v_origin;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         de_q          <= 1'b0;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign o_de          = de_q;
   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_line_start  = line_start_q;
   assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
module tb_video_timing_gen;
   import video_timing_pkg::*;

   // Small raster: H 8/2/2/2 (14), V 4/1/1/1 (7), hsync active-high, vsync active-low.
   localparam int SH_A = 8, SH_FP = 2, SH_S = 2, SH_T = 14;
   localparam int SV_A = 4, SV_FP = 1, SV_S = 1, SV_T = 7;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic [11:0] x;
      logic [11:0] y;
      logic        ls;
      logic        fs;
   } outs_t;

   typedef struct {
      logic  rst_n;
      logic  en;
      outs_t exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en;
   logic        hs, vs, de, ls, fs;
   logic [11:0] x, y;

   logic        rst7_n, en7;
   logic        hs7, vs7, de7, ls7, fs7;
   logic [11:0] x7, y7;

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b0)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
      .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_x(x), .o_y(y),
      .o_line_start(ls), .o_frame_start(fs)
   );

   video_timing_gen dut720 (
      .i_clk(clk), .i_rst_n(rst7_n), .i_en(en7),
      .o_hsync(hs7), .o_vsync(vs7), .o_de(de7), .o_x(x7), .o_y(y7),
      .o_line_start(ls7), .o_frame_start(fs7)
   );

   int    vectors = 0;
   int    miscompares = 0;
   outs_t exp_q[$];
   int    mh = 0, mv = 0;
   vec_t  tbl[20];

   function automatic outs_t mk(input logic d, input logic h, input logic v, input int px,
                                input int py, input logic l, input logic f);
      outs_t o;
      o.de = d; o.hs = h; o.vs = v; o.x = 12'(px); o.y = 12'(py); o.ls = l; o.fs = f;
      return o;
   endfunction

   function automatic outs_t rst_outs();
      return mk(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
   endfunction

   function automatic outs_t sample();
      return {de, hs, vs, x, y, ls, fs};
   endfunction

   task automatic check(input string name, input outs_t act, input outs_t want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b, want de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b",
                  name, act.de, act.hs, act.vs, act.x, act.y, act.ls, act.fs,
                  want.de, want.hs, want.vs, want.x, want.y, want.ls, want.fs);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int want);
      vectors++;
      if (act != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   // Reference raster for the small configuration, stepped once per driven cycle.
   task automatic model_expect(input logic r, input logic e, output outs_t o);
      if (!r || !e) begin
         o  = rst_outs();
         mh = 0;
         mv = 0;
      end else begin
         o = mk((mh < SH_A) && (mv < SV_A),
                (mh >= SH_A + SH_FP) && (mh < SH_A + SH_FP + SH_S),
                !((mv >= SV_A + SV_FP) && (mv < SV_A + SV_FP + SV_S)),
                mh, mv,
                (mh == 0) && (mv < SV_A),
                (mh == 0) && (mv == 0));
         mh++;
         if (mh == SH_T) begin
            mh = 0;
            mv++;
            if (mv == SV_T) mv = 0;
         end
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, compare after the edge.
   task automatic drive_and_check(input logic r, input logic e, input outs_t want, input string name);
      outs_t got, q;
      @(negedge clk);
      rst_n = r;
      en    = e;
      exp_q.push_back(want);
      @(posedge clk);
      #1;
      got = sample();
      q   = exp_q.pop_front();
      check(name, got, q);
   endtask

   task automatic step(input logic r, input logic e, input string name);
      outs_t want;
      model_expect(r, e, want);
      drive_and_check(r, e, want, name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs_pos[$];
      int de_cnt, vs_low, vs_bad, found;
      int ls_pos[$];
      int de_line0, hs_width, hs_first, vs_act, fs_extra, ls_y1, x_last;

      // Table: reset, first line and a bit, enable drop and restart.
      tbl[0] = '{1'b0, 1'b1, rst_outs()};
      tbl[1] = '{1'b1, 1'b1, mk(1, 0, 1, 0, 0, 1, 1)};
      for (int i = 1; i <= 7; i++) tbl[1+i] = '{1'b1, 1'b1, mk(1, 0, 1, i, 0, 0, 0)};
      tbl[9]  = '{1'b1, 1'b1, mk(0, 0, 1, 8, 0, 0, 0)};
      tbl[10] = '{1'b1, 1'b1, mk(0, 0, 1, 9, 0, 0, 0)};
      tbl[11] = '{1'b1, 1'b1, mk(0, 1, 1, 10, 0, 0, 0)};
      tbl[12] = '{1'b1, 1'b1, mk(0, 1, 1, 11, 0, 0, 0)};
      tbl[13] = '{1'b1, 1'b1, mk(0, 0, 1, 12, 0, 0, 0)};
      tbl[14] = '{1'b1, 1'b1, mk(0, 0, 1, 13, 0, 0, 0)};
      tbl[15] = '{1'b1, 1'b1, mk(1, 0, 1, 0, 1, 1, 0)};
      tbl[16] = '{1'b1, 1'b1, mk(1, 0, 1, 1, 1, 0, 0)};
      tbl[17] = '{1'b1, 1'b0, rst_outs()};
      tbl[18] = '{1'b1, 1'b0, rst_outs()};
      tbl[19] = '{1'b1, 1'b1, mk(1, 0, 1, 0, 0, 1, 1)};

      rst_n = 1'b1; en = 1'b1; rst7_n = 1'b1; en7 = 1'b0;
      #1;
      rst_n = 1'b0; rst7_n = 1'b0;
      #2;
      check("reset_state", sample(), rst_outs());

      foreach (tbl[i]) drive_and_check(tbl[i].rst_n, tbl[i].en, tbl[i].exp, $sformatf("tbl[%0d]", i));

      // Three frames from a clean restart.
      step(1'b1, 1'b0, "park");
      de_cnt = 0; vs_low = 0; vs_bad = 0;
      for (int i = 0; i < 3 * SH_T * SV_T; i++) begin
         step(1'b1, 1'b1, "frame_run");
         if (fs === 1'b1) fs_pos.push_back(i);
         if (de === 1'b1) de_cnt++;
         if (vs === 1'b0) begin
            vs_low++;
            if (y != 12'd5) vs_bad++;
         end
      end
      step(1'b1, 1'b1, "frame_wrap");
      if (fs === 1'b1) fs_pos.push_back(3 * SH_T * SV_T);
      chk_int("fs_count", fs_pos.size(), 4);
      for (int i = 1; i < fs_pos.size(); i++) chk_int("fs_spacing", fs_pos[i] - fs_pos[i-1], 98);
      chk_int("de_cycles_3frames", de_cnt, 96);
      chk_int("vsync_low_3frames", vs_low, 42);
      chk_int("vsync_low_off_line5", vs_bad, 0);

      // Enable drop at pixel (5,2).
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (de === 1'b1 && x == 12'd5 && y == 12'd2) begin
            found = 1;
            break;
         end
         step(1'b1, 1'b1, "seek_5_2");
      end
      chk_int("reach_5_2", found, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "en_gap");
      step(1'b1, 1'b1, "en_restart");
      chk_int("en_restart_fs", int'(fs), 1);

      // Asynchronous reset with hsync active.
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (x == 12'd11) begin
            found = 1;
            break;
         end
         step(1'b1, 1'b1, "seek_h11");
      end
      chk_int("reach_h11", found, 1);
      chk_int("hs_before_rst", int'(hs), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", sample(), rst_outs());
      step(1'b0, 1'b1, "rst_hold");
      step(1'b1, 1'b1, "rst_restart");
      step(1'b1, 1'b1, "rst_restart_x1");

      // Default 720p: first two lines and the start of the third.
      @(negedge clk);
      rst7_n = 1'b1;
      en7    = 1'b1;
      de_line0 = 0; hs_width = 0; hs_first = -1; vs_act = 0; fs_extra = 0; ls_y1 = -1; x_last = -1;
      for (int k = 0; k <= 3400; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            vectors++;
            if ({de7, hs7, vs7, x7, y7, ls7, fs7} !== {3'b100, 12'd0, 12'd0, 2'b11}) begin
               miscompares++;
               $display("FAIL p720_first: got de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b, want 1 0 0 0 0 1 1",
                        de7, hs7, vs7, x7, y7, ls7, fs7);
            end
         end
         if (k < 1650) begin
            if (de7 === 1'b1) de_line0++;
            if (hs7 === 1'b1) begin
               hs_width++;
               if (hs_first < 0) hs_first = k;
            end
         end
         if (k == 1649) x_last = int'(x7);
         if (ls7 === 1'b1) begin
            ls_pos.push_back(k);
            if (k == 1650) ls_y1 = int'(y7);
         end
         if (vs7 === 1'b1) vs_act++;
         if (k > 0 && fs7 === 1'b1) fs_extra++;
      end
      chk_int("p720_de_per_line", de_line0, 1280);
      chk_int("p720_hsync_width", hs_width, 40);
      chk_int("p720_hsync_start", hs_first, 1390);
      chk_int("p720_last_x", x_last, 1649);
      chk_int("p720_ls_count", ls_pos.size(), 3);
      if (ls_pos.size() >= 2) chk_int("p720_line_period", ls_pos[1] - ls_pos[0], 1650);
      if (ls_pos.size() >= 3) chk_int("p720_line_period2", ls_pos[2] - ls_pos[1], 1650);
      chk_int("p720_y_line1", ls_y1, 1);
      chk_int("p720_y_line2", int'(y7), 2);
      chk_int("p720_vsync_idle", vs_act, 0);
      chk_int("p720_no_early_fs", fs_extra, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
